// File: rtl/i2c_pkg.sv
// i2c_pkg: shared state type, R/W encodings and counter sizing for the I2C byte sequencer.
package i2c_pkg;
  typedef enum logic [3:0] {
    IDLE, START, ADDR, ADDR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, STOP
  } i2c_seq_state_t;
  localparam logic I2C_RW_WRITE = 1'b0;
  localparam logic I2C_RW_READ  = 1'b1;
  function automatic int cnt_w(input int a, input int b);
    return $clog2((a > b ? a : b) + 1);
  endfunction
endpackage

// File: rtl/i2c_phase_edge.sv
// i2c_phase_edge: registers the generator's data_clk phase and flags its rising and falling edges.
module i2c_phase_edge (
  input  logic clk,
  input  logic rst,
  input  logic data_clk,
  output logic rise,
  output logic fall
);
  logic q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) q <= 1'b0;
    else q <= data_clk;
  assign rise = data_clk & ~q;
  assign fall = ~data_clk & q;
endmodule

// File: rtl/i2c_master_seq.sv
// i2c_master_seq: byte-level I2C master walking START, addr+R/W, ACK, data, ACK, STOP on data_clk edges.
// Define I2C_SEQ_NACK_ABORT_EN to skip the data phase after an address NACK.
module i2c_master_seq
  import i2c_pkg::*;
#(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              data_clk,
  input  logic              sda_in,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_rw,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              scl_ena,
  output logic              sda_oe,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_nack,
  output logic              busy
);
  localparam int CW = cnt_w(ADDR_W, DATA_W);
  i2c_seq_state_t state, state_nxt;
  logic rise, fall, armed, rw, nk, got, last, abort;
  logic [ADDR_W:0] sh;
  logic [DATA_W-1:0] wd, rd;
  logic [CW-1:0] bitcnt;
  i2c_phase_edge u_edge (
    .clk      (clk),
    .rst      (rst),
    .data_clk (data_clk),
    .rise     (rise),
    .fall     (fall)
  );
  assign last      = bitcnt == '0;
  assign cmd_ready = state == IDLE;
  assign busy      = state != IDLE;
`ifdef I2C_SEQ_NACK_ABORT_EN
  assign abort = sda_in;
`else
  assign abort = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nxt;
  // ACK and STOP slots span a rise then a fall; armed marks that the rise was seen.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      state_nxt = cmd_valid ? START : IDLE;
      START:     state_nxt = fall ? ADDR : START;
      ADDR:      state_nxt = (rise && last) ? ADDR_ACK : ADDR;
      ADDR_ACK:  if (fall && armed) state_nxt = abort ? STOP : (rw == I2C_RW_WRITE) ? WDATA : RDATA;
      WDATA:     state_nxt = (rise && last) ? WDATA_ACK : WDATA;
      WDATA_ACK: state_nxt = (fall && armed) ? STOP : WDATA_ACK;
      RDATA:     state_nxt = (fall && last) ? RDATA_ACK : RDATA;
      RDATA_ACK: state_nxt = rise ? STOP : RDATA_ACK;
      STOP:      state_nxt = rsp_valid ? IDLE : STOP;
      default:   state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh        <= '0;
      wd        <= '0;
      rd        <= '0;
      bitcnt    <= '0;
      rw        <= 1'b0;
      nk        <= 1'b0;
      got       <= 1'b0;
      armed     <= 1'b0;
      scl_ena   <= 1'b0;
      sda_oe    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_nack  <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: if (cmd_valid) begin
          sh      <= {cmd_addr, cmd_rw};
          rw      <= cmd_rw;
          wd      <= cmd_wdata;
          nk      <= 1'b0;
          got     <= 1'b0;
          armed   <= 1'b0;
          scl_ena <= 1'b1;
        end
        START: if (fall) begin
          sda_oe <= 1'b1;
          bitcnt <= CW'(ADDR_W);
        end
        ADDR: if (rise) begin
          sda_oe <= ~sh[ADDR_W];
          sh     <= sh << 1;
          bitcnt <= bitcnt - 1'b1;
        end
        ADDR_ACK, WDATA_ACK: if (rise) begin
          sda_oe <= 1'b0;
          armed  <= 1'b1;
        end else if (fall && armed) begin
          nk     <= nk | sda_in;
          armed  <= 1'b0;
          bitcnt <= CW'(DATA_W - 1);
        end
        WDATA: if (rise) begin
          sda_oe <= ~wd[DATA_W-1];
          wd     <= wd << 1;
          bitcnt <= bitcnt - 1'b1;
        end
        RDATA: if (rise) sda_oe <= 1'b0;
        else if (fall) begin
          rd     <= {rd[DATA_W-2:0], sda_in};
          bitcnt <= bitcnt - 1'b1;
          got    <= last;
        end
        RDATA_ACK: if (rise) sda_oe <= 1'b0;
        STOP: if (!rsp_valid) begin
          if (rise) begin
            sda_oe <= 1'b1;
            armed  <= 1'b1;
          end else if (fall && armed) begin
            sda_oe    <= 1'b0;
            armed     <= 1'b0;
            scl_ena   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_nack  <= nk;
            if (got) rsp_rdata <= rd;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_i2c_master_seq.sv
// tb_i2c_master_seq: table, hand-written and random transactions checked against a bus-level slave and reference model.
module tb_i2c_master_seq;
`ifdef I2C_SEQ_NACK_ABORT_EN
  localparam bit ABORT = 1'b1;
`else
  localparam bit ABORT = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b0, cmd_valid = 1'b0, cmd_rw = 1'b0;
  logic data_clk, sda_in, cmd_ready, scl_ena, sda_oe, rsp_valid, rsp_nack, busy;
  logic [6:0] cmd_addr = '0;
  logic [7:0] cmd_wdata = '0, rsp_rdata;
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  i2c_master_seq dut (
    .clk       (clk),
    .rst       (rst),
    .data_clk  (data_clk),
    .sda_in    (sda_in),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_rw    (cmd_rw),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .scl_ena   (scl_ena),
    .sda_oe    (sda_oe),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_nack  (rsp_nack),
    .busy      (busy)
  );
  // Clock generator model: 8-clk phase, high for ph 0..3; one optional 200-clk stretch while high.
  logic [2:0] ph = 3'd0;
  logic stall_go = 1'b0;
  int st = 0;
  always @(posedge clk)
    if (stall_go && ph == 3'd2 && st != 200) st <= st + 1;
    else ph <= ph + 3'd1;
  assign data_clk = ~ph[2];
  // Slave and bus monitor: SDA is sampled mid SCL-high (ph 3); SDA edges while data_clk is low are START/STOP.
  logic pull = 1'b0, prev_oe = 1'b0, started = 1'b0, stop_seen = 1'b0;
  int slots = 0;
  bit got_q[$];
  logic t_rw = 1'b0, t_ack_a = 1'b0, t_ack_d = 1'b0;
  logic [7:0] t_rd = '0;
  assign sda_in = ~sda_oe & ~pull;
  function automatic logic slave_pull(input int s);
    if (s == 9) return t_ack_a;
    if (!t_rw && s == 18) return t_ack_a & t_ack_d;
    if (t_rw && s >= 10 && s <= 17) return t_ack_a & ~t_rd[3'(17 - s)];
    return 1'b0;
  endfunction
  always @(negedge clk) begin
    if (!rst) begin
      started = 1'b0;
      pull = 1'b0;
    end else begin
      if (sda_oe != prev_oe && !data_clk) begin
        if (sda_oe) begin
          started = 1'b1;
          stop_seen = 1'b0;
          slots = 0;
          got_q.delete();
        end else if (started) begin
          started = 1'b0;
          stop_seen = 1'b1;
          pull = 1'b0;
        end
      end
      if (started && ph == 3'd2) pull = slave_pull(slots + 1);
      if (started && ph == 3'd3) begin
        got_q.push_back(~sda_oe & ~pull);
        slots++;
      end
    end
    prev_oe = sda_oe;
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask
  task automatic fail(input string nm, input string why);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: %s", nm, why);
  endtask
  // Reference model: expected SDA value in every SCL-high slot from START to STOP, plus response fields.
  bit exp_q[$];
  logic exp_nack;
  logic [7:0] exp_rdata, mdl_rdata = '0;
  task automatic prep(input logic rw, input logic [6:0] a, input logic [7:0] wd,
                      input logic aa, input logic ad, input logic [7:0] rd);
    bit ran;
    t_rw = rw; t_ack_a = aa; t_ack_d = ad; t_rd = rd;
    cmd_rw = rw; cmd_addr = a; cmd_wdata = wd;
    ran = !(ABORT && !aa);
    exp_q.delete();
    for (int i = 6; i >= 0; i--) exp_q.push_back(a[i]);
    exp_q.push_back(rw);
    exp_q.push_back(!aa);
    if (ran) begin
      for (int i = 7; i >= 0; i--) exp_q.push_back(rw ? (!aa | rd[i]) : wd[i]);
      exp_q.push_back(rw ? 1'b1 : !(aa && ad));
    end
    exp_q.push_back(1'b0);
    exp_nack = !aa || (ran && !rw && !ad);
    if (rw && ran) mdl_rdata = aa ? rd : 8'hFF;
    exp_rdata = mdl_rdata;
  endtask
  task automatic cmp_stream(input string nm);
    string gs = "", es = "";
    bit bad;
    foreach (got_q[i]) gs = {gs, got_q[i] ? "1" : "0"};
    foreach (exp_q[i]) es = {es, exp_q[i] ? "1" : "0"};
    bad = got_q.size() != exp_q.size();
    foreach (exp_q[i]) if (!bad && got_q[i] != exp_q[i]) bad = 1'b1;
    n_cmp++;
    if (bad) begin
      n_bad++;
      $display("FAIL %s.stream: sda bits %s, want %s", nm, gs, es);
    end
  endtask
  task automatic issue(input string nm);
    int n = 0;
    while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
    if (!cmd_ready) fail(nm, "cmd_ready never rose");
    cmd_valid = 1'b1;
    @(negedge clk);
    chk({nm, ".scl_on"}, 32'(scl_ena), 1);
    chk({nm, ".busy"}, 32'(busy), 1);
    cmd_valid = 1'b0;
  endtask
  task automatic finish(input string nm);
    int n = 0;
    while (!rsp_valid && n < 4000) begin @(negedge clk); n++; end
    if (!rsp_valid) begin
      fail(nm, "no rsp_valid within 4000 clk");
      return;
    end
    chk({nm, ".nack"}, 32'(rsp_nack), 32'(exp_nack));
    chk({nm, ".rdata"}, 32'(rsp_rdata), 32'(exp_rdata));
    chk({nm, ".ready_in_rsp"}, 32'(cmd_ready), 0);
    @(negedge clk);
    chk({nm, ".pulse"}, 32'(rsp_valid), 0);
    chk({nm, ".ready"}, 32'(cmd_ready), 1);
    chk({nm, ".scl_off"}, 32'(scl_ena), 0);
    chk({nm, ".stop"}, 32'(stop_seen), 1);
    cmp_stream(nm);
  endtask
  task automatic wait_at(input int s, input logic [2:0] p, input string nm);
    int n = 0;
    while (!(slots == s && ph == p) && n < 2000) begin @(negedge clk); n++; end
    if (!(slots == s && ph == p)) fail(nm, "timed out waiting for bit slot");
  endtask
  typedef struct {
    logic rw; logic [6:0] addr; logic [7:0] wdata;
    logic ack_a; logic ack_d; logic [7:0] rd;
    logic nack; logic [7:0] rdata;
  } vec_t;
  vec_t tbl[6];
  initial begin
    int viol, seen, chg;
    logic oe0;
    tbl[0] = '{1'b0, 7'h50, 8'hA5, 1'b1, 1'b1, 8'h00, 1'b0, 8'h00};
    tbl[1] = '{1'b1, 7'h50, 8'h00, 1'b1, 1'b1, 8'h3C, 1'b0, 8'h3C};
    tbl[2] = '{1'b0, 7'h2A, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 8'h3C};
    tbl[3] = '{1'b0, 7'h33, 8'h0F, 1'b0, 1'b1, 8'h00, 1'b1, 8'h3C};
    tbl[4] = '{1'b1, 7'h7F, 8'h00, 1'b1, 1'b1, 8'h81, 1'b0, 8'h81};
    tbl[5] = '{1'b0, 7'h00, 8'h5A, 1'b1, 1'b1, 8'h00, 1'b0, 8'h81};
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("reset.ready", 32'(cmd_ready), 1);
    chk("reset.scl", 32'(scl_ena), 0);
    chk("reset.sda", 32'(sda_oe), 0);
    chk("reset.rsp_valid", 32'(rsp_valid), 0);
    chk("reset.rdata", 32'(rsp_rdata), 0);
    chk("reset.nack", 32'(rsp_nack), 0);
    chk("reset.busy", 32'(busy), 0);
    foreach (tbl[i]) begin
      prep(tbl[i].rw, tbl[i].addr, tbl[i].wdata, tbl[i].ack_a, tbl[i].ack_d, tbl[i].rd);
      exp_nack = tbl[i].nack;
      exp_rdata = tbl[i].rdata;
      issue($sformatf("tbl%0d", i));
      finish($sformatf("tbl%0d", i));
    end
    prep(1'b0, 7'h50, 8'hFF, 1'b0, 1'b1, 8'h00);
    issue("addr_nack");
    finish("addr_nack");
    chk("addr_nack.slots", 32'(got_q.size()), ABORT ? 10 : 19);
    prep(1'b0, 7'h12, 8'hC3, 1'b1, 1'b1, 8'h00);
    cmd_valid = 1'b1;
    @(negedge clk);
    chk("b2b.scl_on", 32'(scl_ena), 1);
    cmd_rw = 1'b1; cmd_addr = 7'h21; cmd_wdata = 8'h00;
    viol = 0;
    for (int n = 0; n < 4000 && !rsp_valid; n++) begin
      if (cmd_ready) viol++;
      @(negedge clk);
    end
    chk("b2b.ready_low", 32'(viol), 0);
    finish("b2b.a");
    prep(1'b1, 7'h21, 8'h00, 1'b1, 1'b1, 8'h96);
    @(negedge clk);
    chk("b2b.accept", 32'(scl_ena), 1);
    chk("b2b.ready_drop", 32'(cmd_ready), 0);
    cmd_valid = 1'b0;
    finish("b2b.b");
    prep(1'b0, 7'h5A, 8'h3C, 1'b1, 1'b1, 8'h00);
    issue("stretch");
    wait_at(3, 3'd1, "stretch.wait");
    stall_go = 1'b1;
    oe0 = sda_oe;
    chg = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (sda_oe != oe0 || !busy) chg++;
    end
    chk("stretch.hold", 32'(chg), 0);
    finish("stretch");
    prep(1'b0, 7'h50, 8'hA5, 1'b1, 1'b1, 8'h00);
    issue("midrst");
    wait_at(12, 3'd2, "midrst.wait");
    rst = 1'b0;
    @(negedge clk);
    chk("midrst.sda", 32'(sda_oe), 0);
    chk("midrst.scl", 32'(scl_ena), 0);
    chk("midrst.ready", 32'(cmd_ready), 1);
    chk("midrst.busy", 32'(busy), 0);
    chk("midrst.rdata", 32'(rsp_rdata), 0);
    rst = 1'b1;
    mdl_rdata = '0;
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      if (rsp_valid) seen++;
      @(negedge clk);
    end
    chk("midrst.no_rsp", 32'(seen), 0);
    for (int k = 0; k < 16; k++) begin
      prep(1'($urandom_range(0, 1)), 7'($urandom_range(0, 127)), 8'($urandom_range(0, 255)),
           1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 4) != 0), 8'($urandom_range(0, 255)));
      issue($sformatf("rnd%0d", k));
      finish($sformatf("rnd%0d", k));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/i2c_master_seq.md
# i2c_master_seq

Byte-level I2C master sequencer that drives the I2C clock-stretch generator. It accepts single-byte read or write commands, enables the generator's SCL, and walks START, address+R/W, ACK, data byte, ACK and STOP in step with the generator's `data_clk` phase. It sits between the host register interface and the clock generator / SDA pad, and is the only block that drives SDA.

## Interface
- `ADDR_W`, default 7: slave address width.
- `DATA_W`, default 8: data byte width. The bit counter is sized from it.
- `clk` in 1: system clock, shared with the clock generator.
- `rst` in 1: asynchronous, active-low reset.
- `data_clk` in 1: phase output of the clock generator.
  - Rising edge = drive point (SCL low).
  - Falling edge = sample point (SCL high).
- `sda_in` in 1: synchronised SDA pad level.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: command accepted when `cmd_valid & cmd_ready`.
- `cmd_rw` in 1: 0 = write, 1 = read.
- `cmd_addr` in ADDR_W: slave address.
- `cmd_wdata` in DATA_W: write byte.
- `scl_ena` out 1: 1 while a transaction is active. Fed inverted to the generator's `scl_not_ena`.
- `sda_oe` out 1: 1 pulls SDA low, 0 releases it.
- `rsp_valid` out 1: one-cycle completion pulse.
- `rsp_rdata` out DATA_W: read byte, held until the next `rsp_valid`.
- `rsp_nack` out 1: any slave NACK in the transaction, held until the next `rsp_valid`.
- `busy` out 1: high in every state except IDLE.

## Operation
- **Reset values:** `cmd_ready`=1, `scl_ena`=0, `sda_oe`=0, `rsp_valid`=0, `rsp_rdata`=0, `rsp_nack`=0, `busy`=0, state IDLE.
- **Edge detect:** `data_clk` is registered once. `rise = data_clk & ~q`, `fall = ~data_clk & q`. The register resets to 0. Edges are ignored in IDLE.
- **Command capture:** on handshake, latch `{addr, rw}` into the shift register, latch `wdata`, clear the nack flag, set `scl_ena`=1, go to START.
- **START:** on `fall` (SCL high), set `sda_oe`=1. This is the START condition. Go to ADDR with bitcnt = ADDR_W.
- **ADDR:** on each `rise`, drive the shift MSB as `sda_oe = ~bit`, MSB first. After bit 0 (R/W) is driven, go to ADDR_ACK.
- **ADDR_ACK:**
  - On `rise`, release SDA.
  - On the next `fall`, sample `sda_in`; 1 = NACK and sets the nack flag.
  - Then go to WDATA or RDATA, subject to Configuration.
- **WDATA:** shift `DATA_W` bits as in ADDR, then go to WDATA_ACK. WDATA_ACK samples the slave ACK the same way as ADDR_ACK, then goes to STOP.
- **RDATA:**
  - On `rise`, release SDA.
  - On `fall`, shift in `sda_in`, MSB first, `DATA_W` bits.
  - Then go to RDATA_ACK.
- **RDATA_ACK:** on `rise`, master drives NACK (`sda_oe`=0), then goes to STOP.
- **STOP:**
  - On `rise`, set `sda_oe`=1.
  - On the next `fall`, set `sda_oe`=0. This is the STOP condition.
  - Then set `scl_ena`=0, pulse `rsp_valid`, go to IDLE.
- **Simultaneous events:** a handshake in the same cycle as `rsp_valid` is impossible, because `cmd_ready`=0 until the state is IDLE.
- **Reset mid-operation:** asynchronous return to reset values. SDA is released, no `rsp_valid` is issued, the command is lost.

## Timing
- `cmd_ready` = (state == IDLE), combinational from state.
- **Latency:** handshake to `scl_ena`=1 is 1 clk. State actions occur in the clk after the `data_clk` edge (one register of delay).
- **Transaction length** in SCL periods (data_clk cycles):
  - ADDR_W + 1 for address + ACK.
  - DATA_W + 1 for data + ACK.
  - About 1.5 for START plus about 1 for STOP.
- `rsp_valid` is high exactly 1 clk, in the cycle after the STOP release. `rsp_rdata` and `rsp_nack` are valid in that cycle and held afterwards.
- `data_clk` may be held (stretched) for any length. The FSM only advances on edges.

## Configuration
- `I2C_SEQ_NACK_ABORT_EN`:
  - Defined: an address NACK jumps ADDR_ACK → STOP, skipping the data phase. `rsp_rdata` is unchanged.
  - Undefined: the data phase always runs. The NACK is only reported through `rsp_nack`.

## Structure
- Package `i2c_pkg`:
  - State enum `i2c_seq_state_t`: IDLE, START, ADDR, ADDR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, STOP.
  - Constants `I2C_RW_WRITE`=0 and `I2C_RW_READ`=1.
- One sub-module, `i2c_phase_edge`: `data_clk` register plus the rise/fall pulses.

## Test plan
All scenarios use a generator model with `data_clk` period 8 clk.
- **Write, ACKed:** write addr 0x50, data 0xA5, slave ACKs → SDA bit sequence 1010000,0,ACK,10100101,ACK, then STOP; `rsp_nack`=0.
- **Read:** read addr 0x50, slave returns 0x3C → `rsp_rdata`=0x3C, master NACK bit = 1, `rsp_nack`=0.
- **Address NACK:** address NACK on write 0x50/0xFF → with the macro, no data bits are driven before STOP and `rsp_nack`=1; without it, 8 data bits are driven and `rsp_nack`=1.
- **Back-to-back commands:** `cmd_valid` held through a transaction → `cmd_ready`=0 until IDLE; the second command is accepted 1 clk after `rsp_valid`.
- **Reset mid-transfer:** `rst`=0 during the 4th data bit → next clk `sda_oe`=0, `scl_ena`=0, `cmd_ready`=1, no `rsp_valid`.
- **Stretched clock:** `data_clk` held high 200 clk during ADDR → no state change; the address completes correctly afterwards.
